// File: rtl/axi4_lite_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_slave_mem
//  Description : AXI4-Lite slave backed by an on-chip word memory. The write
//                and read channels run independently. Writes honour byte
//                strobes. Addresses outside the window answer SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    aclk,
  input  logic                    reset,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response channel
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_NBYTES = DATA_WIDTH / 8;
  localparam int c_LSB    = $clog2(c_NBYTES);
  localparam int c_IDX_W  = $clog2(MEM_DEPTH);
  // Window size in bytes, one bit wider than the address so the compare
  // cannot overflow when the window spans the whole address space.
  localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * c_NBYTES);
  localparam logic [1:0]          c_OKAY      = 2'b00;
  localparam logic [1:0]          c_SLVERR    = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_e;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  wstate_e                 wstate_q,   wstate_d;
  logic                    aw_held_q,  aw_held_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q,  aw_addr_d;
  logic                    w_held_q,   w_held_d;
  logic [DATA_WIDTH-1:0]   w_data_q,   w_data_d;
  logic [c_NBYTES-1:0]     w_strb_q,   w_strb_d;
  logic [1:0]              bresp_q,    bresp_d;

  rstate_e                 rstate_q,   rstate_d;
  logic [DATA_WIDTH-1:0]   rdata_q,    rdata_d;
  logic [1:0]              rresp_q,    rresp_d;

  // --------------------------------------------------------------------------
  // Write-side combinational signals
  // --------------------------------------------------------------------------
  logic                    w_awready;
  logic                    w_wready;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_commit;
  logic [ADDR_WIDTH-1:0]   w_cmt_addr;
  logic [DATA_WIDTH-1:0]   w_cmt_data;
  logic [c_NBYTES-1:0]     w_cmt_strb;
  logic [ADDR_WIDTH-1:0]   w_wr_off;
  logic                    w_wr_in_range;
  logic [c_IDX_W-1:0]      w_wr_idx;
  logic                    w_mem_we;
  logic [DATA_WIDTH-1:0]   w_merged;

  // Ready is forced low while reset is high so no handshake is seen during it.
  assign w_awready = !reset && !aw_held_q && (wstate_q == W_IDLE);
  assign w_wready  = !reset && !w_held_q  && (wstate_q == W_IDLE);
  assign w_aw_hs   = s_axi_awvalid && w_awready;
  assign w_w_hs    = s_axi_wvalid  && w_wready;

  // A held value takes priority; otherwise the value handshaking this edge.
  assign w_cmt_addr = aw_held_q ? aw_addr_q : s_axi_awaddr;
  assign w_cmt_data = w_held_q  ? w_data_q  : s_axi_wdata;
  assign w_cmt_strb = w_held_q  ? w_strb_q  : s_axi_wstrb;

  // Commit once both halves of the write are available; never during reset.
  assign w_commit = !reset && (wstate_q == W_IDLE)
                    && (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs);

  assign w_wr_off      = w_cmt_addr - BASE_ADDR;
  assign w_wr_in_range = ({1'b0, w_wr_off} < c_MEM_BYTES);
  assign w_wr_idx      = w_wr_off[c_LSB +: c_IDX_W];
  assign w_mem_we      = w_commit && w_wr_in_range;

  // Merge strobed bytes of the new data over the current word contents.
  always_comb begin
    w_merged = mem_q[w_wr_idx];
    for (int b = 0; b < c_NBYTES; b++) begin
      if (w_cmt_strb[b]) begin
        w_merged[8*b +: 8] = w_cmt_data[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read-side combinational signals
  // --------------------------------------------------------------------------
  logic                    w_arready;
  logic                    w_ar_hs;
  logic [ADDR_WIDTH-1:0]   w_rd_off;
  logic                    w_rd_in_range;
  logic [c_IDX_W-1:0]      w_rd_idx;

  assign w_arready     = !reset && (rstate_q == R_IDLE);
  assign w_ar_hs       = s_axi_arvalid && w_arready;
  assign w_rd_off      = s_axi_araddr - BASE_ADDR;
  assign w_rd_in_range = ({1'b0, w_rd_off} < c_MEM_BYTES);
  assign w_rd_idx      = w_rd_off[c_LSB +: c_IDX_W];

  // --------------------------------------------------------------------------
  // Write FSM: capture AW/W into holding registers, commit, respond on B
  // --------------------------------------------------------------------------
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;

    case (wstate_q)
      W_IDLE: begin
        if (w_aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axi_awaddr;
        end
        if (w_w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s_axi_wdata;
          w_strb_d = s_axi_wstrb;
        end
        if (w_commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = w_wr_in_range ? c_OKAY : c_SLVERR;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wstate_d = W_IDLE;
        end
      end
      default: begin
        wstate_d = W_IDLE;
      end
    endcase
  end

  // Write-side state register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory array: written on an in-range commit, contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      mem_q[w_wr_idx] <= w_merged;
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM: register data/response on AR, hold until R handshake
  // --------------------------------------------------------------------------
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    case (rstate_q)
      R_IDLE: begin
        if (w_ar_hs) begin
          // mem_q is sampled before this edge's write lands, so a same-edge
          // write to the same word is not visible to this read.
          rdata_d  = w_rd_in_range ? mem_q[w_rd_idx] : '0;
          rresp_d  = w_rd_in_range ? c_OKAY : c_SLVERR;
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rstate_d = R_IDLE;
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  // Read-side state register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all forced to zero while reset is asserted
  // --------------------------------------------------------------------------
  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bvalid  = !reset && (wstate_q == W_RESP);
  assign s_axi_bresp   = reset ? 2'b00 : bresp_q;
  assign s_axi_arready = w_arready;
  assign s_axi_rvalid  = !reset && (rstate_q == R_RESP);
  assign s_axi_rdata   = reset ? '0 : rdata_q;
  assign s_axi_rresp   = reset ? 2'b00 : rresp_q;

  // Protection attributes carry no meaning for this memory.
  logic w_unused_ok;
  assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot};

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_slave_mem
//  Description : Directed self-checking bench for axi4_lite_slave_mem.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_mem;

  logic        aclk;
  logic        reset;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;

  axi4_lite_slave_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH (256),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .aclk         (aclk),
    .reset        (reset),
    .s_axi_awaddr (awaddr),
    .s_axi_awprot (awprot),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arprot (arprot),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // full write transaction with bready=1; returns bresp
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    logic aw_f, w_f;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick();
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (bvalid !== 1'b1) begin
      bad++;
      $display("FAIL write_timeout addr=%h bvalid=%b required=1", a, bvalid);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bresp;
    tick();
  endtask

  // full read transaction with rready=1; returns rdata and rresp
  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (rvalid !== 1'b1) begin
      bad++;
      $display("FAIL read_timeout addr=%h rvalid=%b required=1", a, rvalid);
    end
    d = rdata;
    resp = rresp;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_ctl got=%b required=00000", {awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      bad++;
      $display("FAIL reset_data got=%h required=0", {bresp, rresp, rdata});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_reset got=%b required=111", {awready, wready, arready});
    end
    tick();
  endtask

  task automatic test_basic();
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++;
      $display("FAIL basic_b got=%b/%b required=1/00", bvalid, bresp);
    end
    tick();
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
      bad++;
      $display("FAIL basic_r got=%b/%h/%b required=1/deadbeef/00", rvalid, rdata, rresp);
    end
    tick();
  endtask

  task automatic test_w_before_aw();
    logic [1:0]  r;
    logic [31:0] d;
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    total++;
    if (wready !== 1'b0 || bvalid !== 1'b0) begin
      bad++;
      $display("FAIL w_held got wready=%b bvalid=%b required=0/0", wready, bvalid);
    end
    tick(); tick();
    awaddr = 32'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++;
      $display("FAIL w_first_b got=%b/%b required=1/00", bvalid, bresp);
    end
    tick();
    do_write(32'h20, 32'hAABBCCDD, 4'h5, r);
    total++;
    if (r !== 2'b00) begin
      bad++;
      $display("FAIL strb_bresp got=%b required=00", r);
    end
    do_read(32'h20, d, r);
    total++;
    if (d !== 32'h11BB33DD || r !== 2'b00) begin
      bad++;
      $display("FAIL strb_read got=%h/%b required=11bb33dd/00", d, r);
    end
  endtask

  task automatic test_wstrb_zero();
    logic [1:0]  r;
    logic [31:0] d;
    do_write(32'h10, 32'h01020304, 4'h0, r);
    total++;
    if (r !== 2'b00) begin
      bad++;
      $display("FAIL strb0_bresp got=%b required=00", r);
    end
    do_read(32'h10, d, r);
    total++;
    if (d !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL strb0_read got=%h required=deadbeef", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0]  r;
    logic [31:0] d;
    do_write(32'h0, 32'hCAFEF00D, 4'hF, r);
    do_write(32'h400, 32'h12345678, 4'hF, r);
    total++;
    if (r !== 2'b10) begin
      bad++;
      $display("FAIL oob_bresp got=%b required=10", r);
    end
    do_read(32'h0, d, r);
    total++;
    if (d !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL oob_mem_unchanged got=%h required=cafef00d", d);
    end
    do_read(32'h400, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b10) begin
      bad++;
      $display("FAIL oob_read got=%h/%b required=0/10", d, r);
    end
    do_write(32'h3FC, 32'hA5A55A5A, 4'hF, r);
    total++;
    if (r !== 2'b00) begin
      bad++;
      $display("FAIL last_word_bresp got=%b required=00", r);
    end
    do_read(32'h3FF, d, r);
    total++;
    if (d !== 32'hA5A55A5A || r !== 2'b00) begin
      bad++;
      $display("FAIL last_word_read got=%h/%b required=a5a55a5a/00", d, r);
    end
  endtask

  task automatic test_b_stall();
    awaddr = 32'h30; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        bad++;
        $display("FAIL b_stall cyc=%0d got=%b required=10000", i, {bvalid, bresp, awready, wready});
      end
      tick();
    end
    bready = 1'b1;
    tick();
    total++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      bad++;
      $display("FAIL b_release got=%b required=011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_r_stall();
    araddr = 32'h20; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'h11BB33DD || rresp !== 2'b00 || arready !== 1'b0) begin
        bad++;
        $display("FAIL r_stall cyc=%0d got=%b/%h/%b/%b required=1/11bb33dd/00/0",
                 i, rvalid, rdata, rresp, arready);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++;
      $display("FAIL r_release got=%b/%b required=0/1", rvalid, arready);
    end
  endtask

  task automatic test_collision();
    logic [1:0]  r;
    logic [31:0] d;
    do_write(32'h40, 32'h0, 4'hF, r);
    awaddr = 32'h40; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h40;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b1; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL collide_old got=%b/%b/%h required=1/1/00000000", bvalid, rvalid, rdata);
    end
    tick();
    do_read(32'h40, d, r);
    total++;
    if (d !== 32'h5) begin
      bad++;
      $display("FAIL collide_new got=%h required=00000005", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  r;
    logic [31:0] d;
    logic        seen;
    // reset while a B response is pending
    awaddr = 32'h60; wdata = 32'h66; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({awready, wready, arready, bvalid} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_during got=%b required=0000", {awready, wready, arready, bvalid});
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      bad++;
      $display("FAIL mid_reset_after got=%b required=1110", {awready, wready, arready, bvalid});
    end
    bready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bvalid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL stale_b got=%b required=0", seen);
    end
    // reset while only AW is held: held address must be dropped
    awaddr = 32'h80; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL aw_dropped got=%b required=0", seen);
    end
    awaddr = 32'h80; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++;
      $display("FAIL aw_after_reset got=%b/%b required=1/00", bvalid, bresp);
    end
    tick();
    do_read(32'h80, d, r);
    total++;
    if (d !== 32'h77) begin
      bad++;
      $display("FAIL held_w_read got=%h required=00000077", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_wstrb_zero();
    test_out_of_range();
    test_b_stall();
    test_r_stall();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
